rmii_tx_frame_ctrl: RTL and testbench
=====================================

# rmii_tx_frame_ctrl

Frame-level transmit sequencer for the 50 MHz RMII byte sender. It accepts a frame request from the MAC buffer logic and reads the payload out of a synchronous buffer. It feeds the byte sender one byte per handshake in this order: preamble, SFD, payload, zero pad, FCS. It then enforces the inter-frame gap before accepting the next request, at both 10 and 100 Mbit/s.

## Interface
Parameters:
- ADDR_W, 11, payload buffer address and length width
- MIN_LEN, 60, minimum payload+pad byte count, excluding FCS

Ports:
- clk  in  1  50 MHz clock
- rst  in  1  asynchronous reset, active high
- fast_eth  in  1  link speed: 0 = 10 Mbit/s, 1 = 100 Mbit/s; latched at frame accept
- frame_req  in  1  level; a frame is waiting in the buffer
- frame_len  in  ADDR_W  payload byte count; sampled on frame_ack
- frame_ack  out  1  one-cycle pulse when the request is accepted
- frame_done  out  1  one-cycle pulse at the end of the IFG
- busy  out  1  high from frame_ack through the frame_done cycle
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  8  buffer data; valid the cycle after rd_en
- tx_start  out  1  a byte is pending for the sender
- tx_data  out  8  pending byte
- tx_rdy  in  1  sender ready; the byte is handed over in any cycle where tx_start && tx_rdy

## Operation
- Reset values: every output is 0; the state is IDLE; the CRC register is 0xFFFFFFFF.
- The handover of a byte occurs when tx_start && tx_rdy. tx_data stays constant while tx_start=1. After a handover, tx_start drops in the next cycle unless the next byte is already loaded.
- States:
  - IDLE: when frame_req=1, pulse frame_ack, latch len and fast_eth, and go to PRE with tx_data=0x55.
  - PRE: 7 bytes of 0x55, then SFD.
  - SFD: 0xD5. Issue the read for addr 0 in this state. If len=0, go to PAD.
  - PAY: bytes 0..len-1 from the buffer. The handover of byte i issues the read for i+1 when i+1<len.
  - PAD: 0x00 bytes until the payload+pad count reaches max(len, MIN_LEN).
  - FCS: 4 bytes of ~crc, LSB byte first.
  - IFG: wait for tx_rdy=1, then count IFG cycles (48 when fast, 480 when slow, i.e. 12 byte times), then pulse frame_done and return to IDLE.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF. It updates on each PAY or PAD handover; it does not update on PRE, SFD or FCS bytes. The init value is reloaded at frame_ack.
- The byte counter is ADDR_W bits wide and does not wrap within a frame. frame_len is not range-checked; values up to 2^ADDR_W-1 are sent as given.
- frame_req held high across frame_done starts the next frame no earlier than the cycle after frame_done.
- Reset mid-frame aborts immediately: tx_start=0 and no frame_done. The sender shares rst.

## Timing
- frame_req=1 in IDLE at cycle T: frame_ack=1 in T+1; tx_start=1 with 0x55 in T+1.
- For constant bytes (PRE, SFD, PAD, FCS), the next byte is valid in the cycle after the handover.
- For buffer bytes, a handover in cycle T gives rd_en=1 in T+1 and tx_start=1 with the new byte in T+3. This meets the 100 Mbit/s sender rate of 4 cycles per byte with no idle gap.
- A frame must show zero cycles where the sender is ready but the controller has no byte, from the first preamble byte to the last FCS byte, at both speeds.
- Minimum-size frame at 100 Mbit/s: 72 handovers, 4 cycles apart.

## Structure
- Package eth_pkg holds:
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, ETH_PRE_CNT=7
  - CRC32_POLY_REFL, CRC32_INIT, CRC32_RESIDUE=32'hDEBB20E3
  - IFG_CYC_FAST=48, IFG_CYC_SLOW=480
  - the state enum
- Sub-module eth_crc32_d8: combinational next-CRC from (crc[31:0], byte[7:0]). It is reusable by the receive path.

## Test plan
- eth_crc32_d8 fed ASCII "123456789" from the init value -> ~crc = 0xCBF43926.
- 100 Mbit/s, len=64, buffer bytes 0x00..0x3F -> 7×0x55, 0xD5, 64 payload bytes, 4 FCS bytes. Bench CRC over payload+FCS = 0xDEBB20E3. Handovers are exactly 4 cycles apart. frame_done arrives 48 cycles after the final tx_rdy rise.
- 10 Mbit/s, len=5 -> 5 payload bytes, 55 bytes of 0x00, valid FCS. The IFG is 480 cycles. Exactly one frame_ack and one frame_done.
- len=0 -> no rd_en asserted; 60 pad bytes; FCS equals the CRC of 60 zero bytes.
- frame_req held high for two frames -> the second frame_ack comes ≥1 cycle after the first frame_done. There is no tx_start during the IFG.
- rst asserted in the middle of PAY -> all outputs are 0 asynchronously. After release, the block is in IDLE and a new request is handled normally from the preamble.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the transmit sequencer state type.
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam int          ETH_PRE_CNT     = 7;

   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

   localparam int          IFG_CYC_FAST    = 48;
   localparam int          IFG_CYC_SLOW    = 480;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_PAY,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } tx_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide reflected CRC-32 step; shared between transmit and receive paths.
module eth_crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);

   // Fold the byte in LSB first, one polynomial step per bit.
   always_comb begin
      crc_out = crc_in ^ {24'h000000, data_in};
      for (int i = 0; i < 8; i++) begin
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_REFL) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/rmii_tx_frame_ctrl.sv
// Frame sequencer: preamble, SFD, buffered payload, zero pad, FCS, then IFG.
module rmii_tx_frame_ctrl
   import eth_pkg::*;
#(
   parameter int ADDR_W  = 11,
   parameter int MIN_LEN = 60
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fast_eth,
   input  logic              frame_req,
   input  logic [ADDR_W-1:0] frame_len,
   output logic              frame_ack,
   output logic              frame_done,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_rdy
);

   localparam logic [ADDR_W:0] MIN_CNT = (ADDR_W+1)'(MIN_LEN);

   tx_state_t         state;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] cnt;
   logic              fast;
   logic              rd_valid;
   logic              buf_full;
   logic [7:0]        pay_buf;
   logic [31:0]       crc;
   logic [31:0]       crc_next;
   logic [31:0]       fcs;
   logic [8:0]        ifg_cnt;
   logic              ifg_counting;
   logic              handover;
   logic [ADDR_W:0]   next_cnt;
   logic [ADDR_W:0]   len_ext;

   assign handover = tx_start & tx_rdy;
   assign next_cnt = {1'b0, cnt} + (ADDR_W+1)'(1);
   assign len_ext  = {1'b0, len};
   assign fcs      = ~crc;

   eth_crc32_d8 u_crc (
      .crc_in  (crc),
      .data_in (tx_data),
      .crc_out (crc_next)
   );

   // Whole frame sequence; byte 0 is prefetched during SFD so payload streams without gaps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         len          <= '0;
         cnt          <= '0;
         fast         <= 1'b0;
         rd_valid     <= 1'b0;
         buf_full     <= 1'b0;
         pay_buf      <= 8'h00;
         crc          <= CRC32_INIT;
         ifg_cnt      <= '0;
         ifg_counting <= 1'b0;
         frame_ack    <= 1'b0;
         frame_done   <= 1'b0;
         busy         <= 1'b0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         tx_start     <= 1'b0;
         tx_data      <= 8'h00;
      end else begin
         frame_ack  <= 1'b0;
         frame_done <= 1'b0;
         rd_en      <= 1'b0;
         rd_valid   <= rd_en;
         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               if (frame_req) begin
                  frame_ack    <= 1'b1;
                  busy         <= 1'b1;
                  len          <= frame_len;
                  fast         <= fast_eth;
                  crc          <= CRC32_INIT;
                  cnt          <= '0;
                  buf_full     <= 1'b0;
                  ifg_counting <= 1'b0;
                  tx_start     <= 1'b1;
                  tx_data      <= ETH_PREAMBLE;
                  state        <= ST_PRE;
               end
            end
            ST_PRE: begin
               if (handover) begin
                  if (cnt == ADDR_W'(ETH_PRE_CNT - 1)) begin
                     cnt     <= '0;
                     tx_data <= ETH_SFD;
                     state   <= ST_SFD;
                     if (len != '0) begin
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                     end
                  end else begin
                     cnt <= next_cnt[ADDR_W-1:0];
                  end
               end
            end
            ST_SFD: begin
               if (handover) begin
                  if (len == '0) begin
                     tx_data <= 8'h00;
                     state   <= ST_PAD;
                  end else begin
                     state <= ST_PAY;
                     if (buf_full) begin
                        tx_data  <= pay_buf;
                        buf_full <= 1'b0;
                     end else if (rd_valid) begin
                        tx_data <= rd_data;
                     end else begin
                        tx_start <= 1'b0;
                     end
                  end
               end else if (rd_valid) begin
                  pay_buf  <= rd_data;
                  buf_full <= 1'b1;
               end
            end
            ST_PAY: begin
               if (handover) begin
                  crc <= crc_next;
                  cnt <= next_cnt[ADDR_W-1:0];
                  if (next_cnt == len_ext) begin
                     if (next_cnt >= MIN_CNT) begin
                        tx_data <= ~crc_next[7:0];
                        cnt     <= '0;
                        state   <= ST_FCS;
                     end else begin
                        tx_data <= 8'h00;
                        state   <= ST_PAD;
                     end
                  end else begin
                     tx_start <= 1'b0;
                     rd_en    <= 1'b1;
                     rd_addr  <= next_cnt[ADDR_W-1:0];
                  end
               end else if (rd_valid) begin
                  tx_data  <= rd_data;
                  tx_start <= 1'b1;
               end
            end
            ST_PAD: begin
               if (handover) begin
                  crc <= crc_next;
                  cnt <= next_cnt[ADDR_W-1:0];
                  if (next_cnt >= MIN_CNT) begin
                     tx_data <= ~crc_next[7:0];
                     cnt     <= '0;
                     state   <= ST_FCS;
                  end
               end
            end
            ST_FCS: begin
               if (handover) begin
                  cnt <= next_cnt[ADDR_W-1:0];
                  case (cnt[1:0])
                     2'd0:    tx_data <= fcs[15:8];
                     2'd1:    tx_data <= fcs[23:16];
                     2'd2:    tx_data <= fcs[31:24];
                     default: begin
                        tx_start     <= 1'b0;
                        ifg_counting <= 1'b0;
                        state        <= ST_IFG;
                     end
                  endcase
               end
            end
            ST_IFG: begin
               if (!ifg_counting) begin
                  if (tx_rdy) begin
                     ifg_counting <= 1'b1;
                     ifg_cnt      <= fast ? 9'(IFG_CYC_FAST - 1) : 9'(IFG_CYC_SLOW - 1);
                  end
               end else if (ifg_cnt == 9'd1) begin
                  frame_done <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  ifg_cnt <= ifg_cnt - 9'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rmii_tx_frame_ctrl.sv
// Scoreboard bench for rmii_tx_frame_ctrl with a paced byte-sender model.
module tb_rmii_tx_frame_ctrl;

   localparam int ADDR_W = 11;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              fast_eth = 1'b0;
   logic              frame_req = 1'b0;
   logic [ADDR_W-1:0] frame_len = '0;
   logic              frame_ack, frame_done, busy, rd_en, tx_start;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic [7:0]        tx_data;
   logic              tx_rdy;

   logic [31:0] cu_in, cu_out;
   logic [7:0]  cu_data;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:2047];
   logic [7:0] exp_q [$];
   logic [7:0] obs_q [$];
   int         obs_cyc [$];
   int         ack_cyc [$];
   int         done_cyc [$];
   int         cyc = 0, rd_cnt = 0, gap_cnt = 0, ifg_tx_cnt = 0, hand_cnt = 0;
   int         exp_total = 0, rise_cyc = 0, period = 4;
   logic       prev_rdy = 1'b1;
   logic       first_ack, first_start;
   logic [7:0] first_data;

   rmii_tx_frame_ctrl #(.ADDR_W(ADDR_W), .MIN_LEN(60)) dut (
      .clk        (clk),
      .rst        (rst),
      .fast_eth   (fast_eth),
      .frame_req  (frame_req),
      .frame_len  (frame_len),
      .frame_ack  (frame_ack),
      .frame_done (frame_done),
      .busy       (busy),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_rdy     (tx_rdy)
   );

   eth_crc32_d8 u_crc_unit (
      .crc_in  (cu_in),
      .data_in (cu_data),
      .crc_out (cu_out)
   );

   initial forever #10 clk = ~clk;

   // Byte sender: after each handover it stays busy for period-1 cycles.
   initial begin
      logic hand;
      int   wait_cnt;
      tx_rdy   = 1'b1;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         hand = tx_start && tx_rdy && !rst;
         @(posedge clk);
         #1;
         if (rst) begin
            tx_rdy   = 1'b1;
            wait_cnt = 0;
         end else if (hand) begin
            tx_rdy   = 1'b0;
            wait_cnt = period - 1;
         end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) tx_rdy = 1'b1;
         end
      end
   end

   // Synchronous payload buffer: data appears the cycle after rd_en.
   initial begin
      logic [ADDR_W-1:0] a;
      rd_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rd_en) begin
            a = rd_addr;
            @(posedge clk);
            #1 rd_data = mem[a];
         end
      end
   end

   // Monitor: logs handovers and events mid-cycle.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
         if (frame_ack) begin
            hand_cnt = 0;
            ack_cyc.push_back(cyc);
         end
         if (frame_done) done_cyc.push_back(cyc);
         if (rd_en) rd_cnt++;
         if (tx_rdy && !prev_rdy) rise_cyc = cyc;
         if (busy && hand_cnt < exp_total && tx_rdy && !tx_start) gap_cnt++;
         if (busy && hand_cnt >= exp_total && tx_start) ifg_tx_cnt++;
         if (tx_start && tx_rdy) begin
            obs_q.push_back(tx_data);
            obs_cyc.push_back(cyc);
            hand_cnt++;
         end
      end
      prev_rdy = tx_rdy;
   end

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h000000, d};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [31:0] obs_residue();
      logic [31:0] r;
      r = 32'hFFFFFFFF;
      for (int i = 8; i < obs_q.size(); i++) r = crc_upd(r, obs_q[i]);
      return r;
   endfunction

   task automatic clear_logs();
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
      ack_cyc.delete();
      done_cyc.delete();
      rd_cnt     = 0;
      gap_cnt    = 0;
      ifg_tx_cnt = 0;
   endtask

   task automatic build_expected(input int len);
      logic [31:0] c;
      logic [7:0]  b;
      int          tot;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      tot = (len > 60) ? len : 60;
      for (int i = 0; i < tot; i++) begin
         b = (i < len) ? mem[i] : 8'h00;
         exp_q.push_back(b);
         c = crc_upd(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
      exp_total = 8 + tot + 4;
   endtask

   task automatic start_frame(input logic fast, input int len);
      period = fast ? 4 : 40;
      build_expected(len);
      @(posedge clk);
      #1;
      fast_eth  = fast;
      frame_len = ADDR_W'(len);
      frame_req = 1'b1;
      @(posedge clk);
      #1;
      first_ack   = frame_ack;
      first_start = tx_start;
      first_data  = tx_data;
      frame_req   = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (done_cyc.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({frame_ack, frame_done, busy, rd_en, tx_start} !== 5'b0 || rd_addr !== '0 || tx_data !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs: ack/done/busy/rd/start=%b rd_addr=%h tx_data=%h required all zero",
                  {frame_ack, frame_done, busy, rd_en, tx_start}, rd_addr, tx_data);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, tx_start, frame_ack, rd_en} !== 4'b0) begin
         n_fail++;
         $display("[TB] FAIL idle_after_reset: busy/start/ack/rd=%b required 0000", {busy, tx_start, frame_ack, rd_en});
      end
   endtask

   task automatic test_crc_unit();
      logic [7:0] s [9];
      s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      cu_in = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) begin
         cu_data = s[i];
         #1;
         cu_in = cu_out;
      end
      n_checks++;
      if (~cu_in !== 32'hCBF43926) begin
         n_fail++;
         $display("[TB] FAIL crc_check_string: got %h required cbf43926", ~cu_in);
      end
   endtask

   task automatic test_fast_64();
      logic ok;
      int   bad;
      logic [31:0] res;
      clear_logs();
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
      start_frame(1'b1, 64);
      n_checks++;
      if (first_ack !== 1'b1 || first_start !== 1'b1 || first_data !== 8'h55) begin
         n_fail++;
         $display("[TB] FAIL fast64_accept: ack=%b start=%b data=%h required 1 1 55", first_ack, first_start, first_data);
      end
      wait_done(1, 3000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL fast64_done_timeout: frame_done count=%0d required 1", done_cyc.size());
      end
      n_checks++;
      if (obs_q.size() != 76) begin
         n_fail++;
         $display("[TB] FAIL fast64_count: handovers=%0d required 76", obs_q.size());
      end
      res = obs_residue();
      n_checks++;
      if (res !== 32'hDEBB20E3) begin
         n_fail++;
         $display("[TB] FAIL fast64_residue: got %h required debb20e3", res);
      end
      bad = 0;
      for (int i = 1; i < obs_cyc.size(); i++) if (obs_cyc[i] - obs_cyc[i-1] != 4) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("[TB] FAIL fast64_spacing: %0d handovers not 4 cycles apart, required 0", bad);
      end
      n_checks++;
      if (done_cyc.size() > 0 && done_cyc[0] - rise_cyc != 48) begin
         n_fail++;
         $display("[TB] FAIL fast64_ifg: frame_done %0d cycles after tx_rdy rise, required 48", done_cyc[0] - rise_cyc);
      end
      n_checks++;
      if (gap_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL fast64_gaps: starved cycles=%0d required 0", gap_cnt);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         logic [7:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL fast64_byte[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

   task automatic test_slow_short();
      logic ok;
      logic [31:0] res;
      clear_logs();
      for (int i = 0; i < 5; i++) mem[i] = 8'hA1 + 8'(i);
      start_frame(1'b0, 5);
      n_checks++;
      if (first_ack !== 1'b1 || first_start !== 1'b1 || first_data !== 8'h55) begin
         n_fail++;
         $display("[TB] FAIL slow5_accept: ack=%b start=%b data=%h required 1 1 55", first_ack, first_start, first_data);
      end
      wait_done(1, 6000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL slow5_done_timeout: frame_done count=%0d required 1", done_cyc.size());
      end
      n_checks++;
      if (done_cyc.size() > 0 && done_cyc[0] - rise_cyc != 480) begin
         n_fail++;
         $display("[TB] FAIL slow5_ifg: frame_done %0d cycles after tx_rdy rise, required 480", done_cyc[0] - rise_cyc);
      end
      repeat (60) @(posedge clk);
      #1;
      n_checks++;
      if (ack_cyc.size() != 1 || done_cyc.size() != 1) begin
         n_fail++;
         $display("[TB] FAIL slow5_pulses: acks=%0d dones=%0d required 1 1", ack_cyc.size(), done_cyc.size());
      end
      n_checks++;
      if (obs_q.size() != 72) begin
         n_fail++;
         $display("[TB] FAIL slow5_count: handovers=%0d required 72", obs_q.size());
      end
      res = obs_residue();
      n_checks++;
      if (res !== 32'hDEBB20E3) begin
         n_fail++;
         $display("[TB] FAIL slow5_residue: got %h required debb20e3", res);
      end
      n_checks++;
      if (gap_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL slow5_gaps: starved cycles=%0d required 0", gap_cnt);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         logic [7:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL slow5_byte[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

   task automatic test_zero_len();
      logic ok;
      clear_logs();
      start_frame(1'b1, 0);
      wait_done(1, 2000, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL zero_done_timeout: frame_done count=%0d required 1", done_cyc.size());
      end
      n_checks++;
      if (rd_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL zero_no_read: rd_en cycles=%0d required 0", rd_cnt);
      end
      n_checks++;
      if (obs_q.size() != 72) begin
         n_fail++;
         $display("[TB] FAIL zero_count: handovers=%0d required 72", obs_q.size());
      end
      n_checks++;
      if (gap_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL zero_gaps: starved cycles=%0d required 0", gap_cnt);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         logic [7:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL zero_byte[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic ok;
      clear_logs();
      for (int i = 0; i < 10; i++) mem[i] = 8'h10 * 8'(i) + 8'h3;
      period = 4;
      build_expected(10);
      build_expected(10);
      @(posedge clk);
      #1;
      fast_eth  = 1'b1;
      frame_len = ADDR_W'(10);
      frame_req = 1'b1;
      for (int i = 0; i < 2000 && ack_cyc.size() < 2; i++) begin
         @(posedge clk);
         #1;
      end
      frame_req = 1'b0;
      wait_done(2, 1000, ok);
      n_checks++;
      if (!ok || ack_cyc.size() != 2) begin
         n_fail++;
         $display("[TB] FAIL b2b_pulses: acks=%0d dones=%0d required 2 2", ack_cyc.size(), done_cyc.size());
      end
      n_checks++;
      if (ack_cyc.size() == 2 && done_cyc.size() >= 1 && ack_cyc[1] < done_cyc[0] + 1) begin
         n_fail++;
         $display("[TB] FAIL b2b_second_ack: ack cycle=%0d required >= %0d", ack_cyc[1], done_cyc[0] + 1);
      end
      n_checks++;
      if (ifg_tx_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_ifg_quiet: tx_start cycles in IFG=%0d required 0", ifg_tx_cnt);
      end
      n_checks++;
      if (obs_q.size() != 144) begin
         n_fail++;
         $display("[TB] FAIL b2b_count: handovers=%0d required 144", obs_q.size());
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         logic [7:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL b2b_byte[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic ok;
      logic [31:0] res;
      clear_logs();
      for (int i = 0; i < 64; i++) mem[i] = 8'hC0 ^ 8'(i);
      start_frame(1'b1, 64);
      for (int i = 0; i < 2000 && hand_cnt < 20; i++) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({frame_ack, frame_done, busy, rd_en, tx_start} !== 5'b0 || rd_addr !== '0 || tx_data !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL midreset_outputs: ack/done/busy/rd/start=%b rd_addr=%h tx_data=%h required all zero",
                  {frame_ack, frame_done, busy, rd_en, tx_start}, rd_addr, tx_data);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      n_checks++;
      if (done_cyc.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_abort: dones=%0d busy=%b required 0 0", done_cyc.size(), busy);
      end
      clear_logs();
      for (int i = 0; i < 5; i++) mem[i] = 8'h5A + 8'(i);
      start_frame(1'b1, 5);
      n_checks++;
      if (first_ack !== 1'b1 || first_start !== 1'b1 || first_data !== 8'h55) begin
         n_fail++;
         $display("[TB] FAIL midreset_restart: ack=%b start=%b data=%h required 1 1 55", first_ack, first_start, first_data);
      end
      wait_done(1, 2000, ok);
      res = obs_residue();
      n_checks++;
      if (!ok || obs_q.size() != 72 || res !== 32'hDEBB20E3) begin
         n_fail++;
         $display("[TB] FAIL midreset_frame: done=%b handovers=%0d residue=%h required 1 72 debb20e3", ok, obs_q.size(), res);
      end
      for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
         logic [7:0] e, o;
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL midreset_byte[%0d]: got %h required %h", i, o, e);
         end
      end
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      test_crc_unit();
      test_fast_64();
      test_slow_short();
      test_zero_len();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
